// File: rtl/tx_burst_ctrl.sv
// Burst sequencer: ramped I/Q envelope, upconverter sync reset, flush and status.
// Optional TX_ABORT_EN macro adds an abort input that forces an early ramp-down.
module tx_burst_ctrl #(
    parameter int RAMP_LOG2 = 4,
    parameter int SYNC_CYC  = 4,
    parameter int FLUSH_CYC = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] burst_len,
    input  logic [15:0] in_i,
    input  logic [15:0] in_q,
    input  logic        in_valid,
    output logic        in_ready,
`ifdef TX_ABORT_EN
    input  logic        abort,
`endif
    output logic [15:0] out_i,
    output logic [15:0] out_q,
    output logic        upc_reset,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        underrun,
    output logic        cfg_err
);

    localparam int N  = 1 << RAMP_LOG2;
    localparam int GW = RAMP_LOG2 + 1;
    localparam logic [15:0] TWO_N      = 16'(2 * N);
    localparam logic [15:0] RU_LAST    = 16'(N - 1);
    localparam logic [15:0] SYNC_LAST  = 16'(SYNC_CYC - 1);
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYC - 1);
    localparam logic [GW-1:0] G_TOP    = {1'b0, {RAMP_LOG2{1'b1}}};
    localparam logic [GW-1:0] G_ZERO   = '0;

    typedef enum logic [2:0] {
        IDLE, SYNC, RAMP_UP, ACTIVE, RAMP_DOWN, FLUSH
    } state_t;

    state_t        state, state_n;
    logic [GW-1:0] gain, gain_n;
    logic [15:0]   cnt, cnt_n;
    logic [15:0]   tmr, tmr_n;
    logic [15:0]   blen, blen_n;
    logic [15:0]   oi_n, oq_n;
    logic          upc_n, done_n, cerr_n, urun_n;
    logic          acc;
    logic [15:0]   act_last;

    logic signed [16+GW:0] prod_i, prod_q;
    logic signed [16+GW:0] shf_i, shf_q;

    // Gain is unsigned 0..N, so it gets a zero sign bit before the multiply.
    assign prod_i = $signed(in_i) * $signed({1'b0, gain});
    assign prod_q = $signed(in_q) * $signed({1'b0, gain});
    assign shf_i  = prod_i >>> RAMP_LOG2;
    assign shf_q  = prod_q >>> RAMP_LOG2;

    assign in_ready = (state == RAMP_UP) || (state == ACTIVE) ||
                      (state == RAMP_DOWN);
    assign acc      = in_ready && in_valid;
    assign tx_busy  = (state != IDLE);
    assign act_last = blen - RU_LAST - 16'd2;

    always_comb begin
        state_n = state;
        gain_n  = gain;
        cnt_n   = cnt;
        tmr_n   = tmr;
        blen_n  = blen;
        oi_n    = 16'd0;
        oq_n    = 16'd0;
        upc_n   = upc_reset;
        done_n  = 1'b0;
        cerr_n  = 1'b0;
        urun_n  = underrun;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len < TWO_N) begin
                        cerr_n = 1'b1;
                    end else begin
                        blen_n  = burst_len;
                        urun_n  = 1'b0;
                        cnt_n   = 16'd0;
                        gain_n  = G_ZERO;
                        tmr_n   = 16'd0;
                        state_n = SYNC;
                    end
                end
            end
            SYNC: begin
                if (tmr == SYNC_LAST) state_n = RAMP_UP;
                else tmr_n = tmr + 16'd1;
            end
            RAMP_UP: begin
                if (acc) begin
                    cnt_n  = cnt + 16'd1;
                    gain_n = gain + 1'b1;
                    if (cnt == RU_LAST) begin
                        if (blen == TWO_N) begin
                            state_n = RAMP_DOWN;
                            gain_n  = G_TOP;
                        end else begin
                            state_n = ACTIVE;
                        end
                    end
                end
            end
            ACTIVE: begin
                if (acc) begin
                    cnt_n = cnt + 16'd1;
                    if (cnt == act_last) begin
                        state_n = RAMP_DOWN;
                        gain_n  = G_TOP;
                    end
                end
            end
            RAMP_DOWN: begin
                if (acc) begin
                    cnt_n = cnt + 16'd1;
                    if (gain == G_ZERO) begin
                        state_n = FLUSH;
                        tmr_n   = 16'd0;
                    end else begin
                        gain_n = gain - 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (tmr == FLUSH_LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    tmr_n = tmr + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef TX_ABORT_EN
        // Ramp down from whatever gain is current, skipping the rest of the burst.
        if (abort && (state == RAMP_UP || state == ACTIVE)) begin
            state_n = RAMP_DOWN;
            gain_n  = (gain == G_ZERO) ? G_ZERO : gain - 1'b1;
        end
`endif

        if (in_ready) begin
            if (acc) begin
                oi_n = shf_i[15:0];
                oq_n = shf_q[15:0];
            end else begin
                urun_n = 1'b1;
            end
        end

        // Release the upconverter together with the first ramp sample.
        if (state_n == IDLE || state_n == SYNC) upc_n = 1'b1;
        else if (acc) upc_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gain      <= '0;
            cnt       <= 16'd0;
            tmr       <= 16'd0;
            blen      <= 16'd0;
            out_i     <= 16'd0;
            out_q     <= 16'd0;
            upc_reset <= 1'b1;
            tx_done   <= 1'b0;
            cfg_err   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            gain      <= gain_n;
            cnt       <= cnt_n;
            tmr       <= tmr_n;
            blen      <= blen_n;
            out_i     <= oi_n;
            out_q     <= oq_n;
            upc_reset <= upc_n;
            tx_done   <= done_n;
            cfg_err   <= cerr_n;
            underrun  <= urun_n;
        end
    end

endmodule
